// File: rtl/axi_dma_writer_if.sv
// rtl/axi_dma_writer_if.sv - AXI3 bus bundle used by the DMA write engine
interface axi_ifc;
  logic [5:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic        awvalid;
  logic        awready;
  logic [5:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [5:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [5:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic        arvalid;
  logic        arready;
  logic [5:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi_dma_writer.sv
// rtl/axi_dma_writer.sv - stream-to-memory AXI3 writer issuing 64-byte INCR bursts
module axi_dma_writer (
  input  logic        clk,
  input  logic        reset,
  axi_ifc.master      m,
  input  logic [31:0] i_data,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_start,
  input  logic [31:0] i_baseaddr,
  input  logic [15:0] i_burst_count,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error
);

  typedef enum logic [2:0] {IDLE, FILL, WADDR, WDATA, WRESP, DONE} state_t;

  state_t      state;
  logic [31:0] data_buf [16];
  logic [4:0]  fill_idx;
  logic [3:0]  drain_idx;
  logic [31:0] txn_addr;
  logic [15:0] txn_count;
  logic        awvalid;
  logic        wvalid;
  logic        wlast;
  logic        bready;
  logic        take;
  logic        unused_inputs;

  assign o_ready = (state == FILL) && !fill_idx[4];
  assign take    = i_valid && o_ready;

  // A whole burst is staged before AW, so W never waits on the producer.
  always_ff @(posedge clk) begin
    if (take) data_buf[fill_idx[3:0]] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      fill_idx  <= '0;
      drain_idx <= '0;
      txn_addr  <= '0;
      txn_count <= '0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      wlast     <= 1'b0;
      bready    <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_error   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            txn_addr  <= {i_baseaddr[31:6], 6'b0};
            txn_count <= i_burst_count;
            o_error   <= 1'b0;
            o_busy    <= 1'b1;
            fill_idx  <= '0;
            state     <= (i_burst_count == 16'd0) ? DONE : FILL;
          end
        end
        FILL: begin
          if (take) begin
            fill_idx <= fill_idx + 5'd1;
            if (fill_idx == 5'd15) begin
              awvalid <= 1'b1;
              state   <= WADDR;
            end
          end
        end
        WADDR: begin
          if (m.awready) begin
            awvalid   <= 1'b0;
            wvalid    <= 1'b1;
            wlast     <= 1'b0;
            drain_idx <= '0;
            state     <= WDATA;
          end
        end
        WDATA: begin
          if (m.wready) begin
            drain_idx <= drain_idx + 4'd1;
            wlast     <= (drain_idx == 4'd14);
            if (wlast) begin
              wvalid <= 1'b0;
              wlast  <= 1'b0;
              bready <= 1'b1;
              state  <= WRESP;
            end
          end
        end
        WRESP: begin
          if (m.bvalid) begin
            bready    <= 1'b0;
            if (m.bresp != 2'b00) o_error <= 1'b1;
            txn_count <= txn_count - 16'd1;
            txn_addr  <= txn_addr + 32'd64;
            fill_idx  <= '0;
            state     <= (txn_count == 16'd1) ? DONE : FILL;
          end
        end
        DONE: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m.awid    = '0;
  assign m.awaddr  = txn_addr;
  assign m.awlen   = 4'd15;
  assign m.awsize  = 3'd2;
  assign m.awburst = 2'd1;
  assign m.awlock  = '0;
  assign m.awcache = '0;
  assign m.awvalid = awvalid;
  assign m.wid     = '0;
  assign m.wdata   = data_buf[drain_idx];
  assign m.wstrb   = 4'hF;
  assign m.wlast   = wlast;
  assign m.wvalid  = wvalid;
  assign m.bready  = bready;
  assign m.arid    = '0;
  assign m.araddr  = '0;
  assign m.arlen   = '0;
  assign m.arsize  = '0;
  assign m.arburst = '0;
  assign m.arlock  = '0;
  assign m.arcache = '0;
  assign m.arvalid = 1'b0;
  assign m.rready  = 1'b0;

  assign unused_inputs = ^{i_baseaddr[5:0], m.bid, m.arready, m.rid, m.rdata,
                           m.rresp, m.rlast, m.rvalid};

endmodule

// File: tb/tb_axi_dma_writer.sv
// tb/tb_axi_dma_writer.sv - scoreboard bench for the AXI3 DMA write engine
module tb_axi_dma_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] i_data = '0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        i_start = 1'b0;
  logic [31:0] i_baseaddr = '0;
  logic [15:0] i_burst_count = '0;
  logic        o_busy;
  logic        o_done;
  logic        o_error;

  axi_ifc axi ();

  axi_dma_writer dut (
    .clk(clk), .reset(reset), .m(axi),
    .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .i_start(i_start), .i_baseaddr(i_baseaddr), .i_burst_count(i_burst_count),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endfunction

  // scoreboard: expected AW addresses and W words for the running job
  logic [31:0] exp_aw[$];
  logic [31:0] exp_w[$];
  logic [31:0] obs_aw[$];
  logic [31:0] obs_w[$];
  bit          model_idle = 1'b1;
  bit          exp_err = 1'b0;
  bit          aw_wait = 1'b0;
  bit          w_wait = 1'b0;
  bit          prod_fire = 1'b0;
  logic [31:0] aw_hold = '0;
  logic [31:0] w_hold = '0;
  bit          wl_hold = 1'b0;
  int          beat = 0;
  int          aw_hs = 0;
  int          w_bursts = 0;
  int          done_pulses = 0;

  // stimulus configuration, written only by the main sequence
  int          aw_delay = 0;
  int          err_burst = -1;
  int          prod_total = 0;
  int          job_id = 0;
  bit          w_toggle = 1'b0;
  bit          gap = 1'b0;
  logic [31:0] data_base = '0;

  // slave and producer state, owned by the responder process
  int          aw_cnt = 0;
  int          b_idx = 0;
  int          prod_n = 0;
  int          cyc = 0;
  int          last_job = 0;
  bit          wtog = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (job_id != last_job) begin
      last_job = job_id;
      prod_n = 0;
      b_idx = 0;
    end
    if (axi.awvalid === 1'b1) begin
      axi.awready = (aw_cnt >= aw_delay);
      aw_cnt++;
    end else begin
      axi.awready = 1'b0;
      aw_cnt = 0;
    end
    wtog = ~wtog;
    axi.wready = w_toggle ? wtog : 1'b1;
    if (axi.bready === 1'b1) begin
      axi.bvalid = 1'b1;
      axi.bresp = (b_idx == err_burst) ? 2'd2 : 2'd0;
    end else begin
      if (axi.bvalid === 1'b1) b_idx++;
      axi.bvalid = 1'b0;
      axi.bresp = 2'd0;
    end
    axi.bid = '0;
    axi.arready = 1'b0;
    axi.rid = '0;
    axi.rdata = '0;
    axi.rresp = '0;
    axi.rlast = 1'b0;
    axi.rvalid = 1'b0;
    if (prod_fire) prod_n++;
    i_valid = (prod_n < prod_total) && (!gap || (cyc % 3 != 2));
    i_data = data_base + 32'(prod_n);
  end

  always @(negedge clk) begin
    prod_fire = !reset && i_valid && o_ready;
    if (reset) begin
      model_idle = 1'b1;
      exp_err = 1'b0;
      aw_wait = 1'b0;
      w_wait = 1'b0;
      beat = 0;
      aw_hs = 0;
      w_bursts = 0;
      exp_aw.delete();
      exp_w.delete();
    end else begin
      check("o_error", o_error, exp_err);
      if (o_done) begin
        model_idle = 1'b1;
        done_pulses++;
        check("done_aw_left", exp_aw.size(), 0);
        check("done_w_left", exp_w.size(), 0);
      end
      check("o_busy", o_busy, !model_idle);
      check("read_tieoff", axi.arvalid | axi.rready, 0);
      if (aw_wait) begin
        check("aw_hold_valid", axi.awvalid, 1);
        check("aw_hold_addr", axi.awaddr, aw_hold);
      end
      if (w_wait) begin
        check("w_hold_valid", axi.wvalid, 1);
        check("w_hold_data", axi.wdata, w_hold);
        check("w_hold_last", axi.wlast, wl_hold);
      end
      if (axi.wvalid) check("w_after_aw", aw_hs > w_bursts, 1);
      if (axi.awvalid && axi.awready) begin
        check("aw_unexpected", exp_aw.size() != 0, 1);
        if (exp_aw.size() != 0) check("awaddr", axi.awaddr, exp_aw.pop_front());
        check("awlen", axi.awlen, 15);
        check("awsize", axi.awsize, 2);
        check("awburst", axi.awburst, 1);
        obs_aw.push_back(axi.awaddr);
        aw_hs++;
      end
      if (axi.wvalid && axi.wready) begin
        check("w_unexpected", exp_w.size() != 0, 1);
        if (exp_w.size() != 0) check("wdata", axi.wdata, exp_w.pop_front());
        check("wlast", axi.wlast, beat == 15);
        check("wstrb", axi.wstrb, 4'hF);
        obs_w.push_back(axi.wdata);
        beat++;
        if (beat == 16) begin
          beat = 0;
          w_bursts++;
        end
      end
      if (axi.bvalid && axi.bready && axi.bresp != 2'd0) exp_err = 1'b1;
      if (i_start && model_idle) begin
        model_idle = 1'b0;
        exp_err = 1'b0;
      end
      aw_wait = axi.awvalid && !axi.awready;
      aw_hold = axi.awaddr;
      w_wait = axi.wvalid && !axi.wready;
      w_hold = axi.wdata;
      wl_hold = axi.wlast;
    end
  end

  int job_d0 = 0;
  int aw_start = 0;
  int w_start = 0;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_job(input logic [31:0] base, input logic [15:0] cnt,
                           input logic [31:0] dbase);
    logic [31:0] abase;
    abase = {base[31:6], 6'b0};
    for (int k = 0; k < int'(cnt); k++) exp_aw.push_back(abase + 32'(k * 64));
    for (int i = 0; i < int'(cnt) * 16; i++) exp_w.push_back(dbase + 32'(i));
    data_base = dbase;
    prod_total = int'(cnt) * 16;
    job_id++;
    job_d0 = done_pulses;
    aw_start = obs_aw.size();
    w_start = obs_w.size();
    tick();
    i_start = 1'b1;
    i_baseaddr = base;
    i_burst_count = cnt;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (done_pulses == job_d0 && t < 3000) begin
      tick();
      t++;
    end
    check({name, "_timeout"}, t < 3000, 1);
    repeat (3) tick();
    check({name, "_done_count"}, done_pulses - job_d0, 1);
  endtask

  initial begin
    repeat (3) tick();
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_error", o_error, 0);
    check("rst_awvalid", axi.awvalid, 0);
    check("rst_wvalid", axi.wvalid, 0);
    check("rst_bready", axi.bready, 0);
    check("rst_ready", o_ready, 0);
    reset = 1'b0;
    repeat (2) tick();

    start_job(32'h1000_0020, 16'd1, 32'h0);
    wait_done("basic");
    check("basic_naw", obs_aw.size() - aw_start, 1);
    check("basic_aw0", obs_aw[aw_start], 32'h1000_0000);
    check("basic_w0", obs_w[w_start], 32'h0);
    check("basic_w15", obs_w[w_start + 15], 32'hF);
    check("basic_err", o_error, 0);

    aw_delay = 3;
    w_toggle = 1'b1;
    gap = 1'b1;
    start_job(32'h2000_0100, 16'd3, 32'h1000);
    begin
      int t;
      t = 0;
      while (!axi.wvalid && t < 1000) begin
        tick();
        t++;
      end
      check("multi_wait_w", axi.wvalid, 1);
    end
    i_start = 1'b1;
    i_baseaddr = 32'h5555_0000;
    i_burst_count = 16'd7;
    tick();
    i_start = 1'b0;
    wait_done("multi");
    check("multi_aw0", obs_aw[aw_start], 32'h2000_0100);
    check("multi_aw1", obs_aw[aw_start + 1], 32'h2000_0140);
    check("multi_aw2", obs_aw[aw_start + 2], 32'h2000_0180);
    check("multi_naw", obs_aw.size() - aw_start, 3);
    check("multi_nw", obs_w.size() - w_start, 48);
    check("multi_w47", obs_w[w_start + 47], 32'h102F);
    aw_delay = 0;
    w_toggle = 1'b0;
    gap = 1'b0;

    err_burst = 0;
    start_job(32'h0000_8000, 16'd2, 32'hE000_0000);
    wait_done("error");
    err_burst = -1;
    check("error_sticky", o_error, 1);
    check("error_nw", obs_w.size() - w_start, 32);
    check("error_aw1", obs_aw[aw_start + 1], 32'h0000_8040);

    start_job(32'h1234_5678, 16'd0, 32'h0);
    check("zero_done_c1", o_done, 0);
    check("zero_busy_c1", o_busy, 1);
    check("zero_err_clr", o_error, 0);
    tick();
    check("zero_done_c2", o_done, 1);
    check("zero_busy_c2", o_busy, 0);
    wait_done("zero");
    check("zero_naw", obs_aw.size() - aw_start, 0);

    start_job(32'hFFFF_FFC0, 16'd2, 32'h7700);
    wait_done("wrap");
    check("wrap_aw0", obs_aw[aw_start], 32'hFFFF_FFC0);
    check("wrap_aw1", obs_aw[aw_start + 1], 32'h0000_0000);

    start_job(32'h3000_0000, 16'd1, 32'hBEEF_0000);
    begin
      int t;
      t = 0;
      while (!(axi.wvalid && beat == 7) && t < 1000) begin
        tick();
        t++;
      end
      check("rstmid_reach_b7", axi.wvalid && beat == 7, 1);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid_awvalid", axi.awvalid, 0);
    check("rstmid_wvalid", axi.wvalid, 0);
    check("rstmid_bready", axi.bready, 0);
    check("rstmid_ready", o_ready, 0);
    check("rstmid_busy", o_busy, 0);
    #1;
    reset = 1'b0;
    repeat (2) tick();
    start_job(32'h0000_4000, 16'd1, 32'h0000_0100);
    wait_done("fresh");
    check("fresh_aw0", obs_aw[aw_start], 32'h0000_4000);
    check("fresh_w0", obs_w[w_start], 32'h0000_0100);
    check("fresh_w15", obs_w[w_start + 15], 32'h0000_010F);
    check("araddr_tie", axi.araddr, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
